// File: rtl/pipe_sequencer.sv
// pipe_sequencer
//   Execution sequencer for the five-stage MIPS pipeline. It owns the global
//   pipeline enable and the PC / IF-ID write enables, and the IF-ID / ID-EX
//   flushes. It obeys run/step/abort commands from the debug unit, and on a
//   HALT it freezes fetch, drains the in-flight instructions, then pulses done.
//
// Parameters
//   DRAIN_CYCLES : cycles after HALT leaves ID until the last older instr retires
//   CNT_W        : width of the enabled-cycle counter
// Ports
//   i_clk, i_reset          : clock (rising edge), async active-high reset
//   i_cmd_valid/i_cmd       : command strobe/code (01 run, 10 step, 11 abort)
//   o_cmd_ready             : command accepted when valid & ready
//   i_pc_src                : branch taken
//   i_load_use              : load-use hazard in ID
//   i_halt_id               : HALT decoded in ID
//   o_pipe_en               : back-end pipeline register / regfile enable
//   o_pc_we, o_ifid_we      : PC and IF/ID write enables
//   o_ifid_flush            : IF/ID flush
//   o_idex_flush            : ID/EX flush
//   o_busy                  : high while running or draining
//   o_done                  : one-cycle pulse on drain completion
//   o_cycle_cnt             : saturating count of enabled cycles
module pipe_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_pc_src,
  input  logic             i_load_use,
  input  logic             i_halt_id,
  output logic             o_pipe_en,
  output logic             o_pc_we,
  output logic             o_ifid_we,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              halt_pend_q, halt_pend_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

  cmd_e              cmd;
  logic              cmd_acc;
  logic              abort_acc;
  logic              halt_qual;
  logic              en;
  logic              in_drain;

  assign cmd       = cmd_e'(i_cmd);
  assign cmd_acc   = i_cmd_valid & o_cmd_ready;
  assign abort_acc = cmd_acc & (cmd == CMD_ABORT);
  // A HALT in the shadow of a taken branch is on the wrong path.
  assign halt_qual = i_halt_id & ~i_pc_src;

  // Enable/flush decode is purely combinational from the state register, so
  // an async reset drops every enable without waiting for a clock edge.
  always_comb begin
    en       = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
    in_drain = (state_q == S_DRAIN);

    o_cmd_ready  = (state_q != S_STEP);
    o_pipe_en    = en;
    o_pc_we      = en & (in_drain ? i_pc_src : (i_pc_src | ~i_load_use));
    o_ifid_we    = en & ~i_load_use;
    o_ifid_flush = en & (i_pc_src | in_drain);
    o_idex_flush = en & (i_pc_src | i_load_use);
    o_busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    o_done       = done_q;
    o_cycle_cnt  = cycle_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halt_pend_d = halt_pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          unique case (cmd)
            CMD_RUN:   state_d = halt_pend_q ? S_DRAIN : S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_ABORT: halt_pend_d = 1'b0;
            default:   ;
          endcase
        end
      end

      S_RUN: begin
        if (abort_acc) begin
          state_d = S_IDLE;
        end else if (halt_qual) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end

      // Single-stepping past a HALT drains one step at a time, using the
      // same counter that a continuous drain uses.
      S_STEP: begin
        state_d = S_IDLE;
        if (halt_pend_q) begin
          if (drain_cnt_q <= DRAIN_ONE) begin
            state_d     = S_DONE;
            halt_pend_d = 1'b0;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q - DRAIN_ONE;
          end
        end else if (halt_qual) begin
          halt_pend_d = 1'b1;
          drain_cnt_d = DRAIN_LOAD;
        end
      end

      S_DRAIN: begin
        if (abort_acc) begin
          // Leave the drain resumable: a later run re-enters DRAIN.
          state_d     = S_IDLE;
          halt_pend_d = 1'b1;
        end else if (i_pc_src) begin
          state_d     = S_RUN;
          drain_cnt_d = '0;
          halt_pend_d = 1'b0;
        end else if (drain_cnt_q <= DRAIN_ONE) begin
          state_d     = S_DONE;
          drain_cnt_d = '0;
          halt_pend_d = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_ONE;
        end
      end

      S_DONE: begin
        if (abort_acc) begin
          state_d     = S_IDLE;
          halt_pend_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d      = (state_d == S_DONE) && (state_q != S_DONE);
    cycle_cnt_d = cycle_cnt_q;
    if (en && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      halt_pend_q <= 1'b0;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_pend_q <= halt_pend_d;
      done_q      <= done_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_pipe_sequencer;

  localparam int unsigned D = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [1:0]  i_cmd = 2'b00;
  logic        i_pc_src = 1'b0;
  logic        i_load_use = 1'b0;
  logic        i_halt_id = 1'b0;

  logic        o_cmd_ready, o_pipe_en, o_pc_we, o_ifid_we, o_ifid_flush;
  logic        o_idex_flush, o_busy, o_done;
  logic [31:0] o_cycle_cnt;

  logic        sat_ready, sat_pipe_en, sat_pc_we, sat_ifid_we, sat_ifid_flush;
  logic        sat_idex_flush, sat_busy, sat_done;
  logic [3:0]  sat_cnt;

  pipe_sequencer #(.DRAIN_CYCLES(D), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_pc_src(i_pc_src), .i_load_use(i_load_use),
    .i_halt_id(i_halt_id), .o_pipe_en(o_pipe_en), .o_pc_we(o_pc_we),
    .o_ifid_we(o_ifid_we), .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
    .o_busy(o_busy), .o_done(o_done), .o_cycle_cnt(o_cycle_cnt)
  );

  // Narrow-counter instance used only to observe saturation.
  pipe_sequencer #(.DRAIN_CYCLES(2), .CNT_W(4)) u_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(sat_ready), .i_pc_src(i_pc_src), .i_load_use(i_load_use),
    .i_halt_id(i_halt_id), .o_pipe_en(sat_pipe_en), .o_pc_we(sat_pc_we),
    .o_ifid_we(sat_ifid_we), .o_ifid_flush(sat_ifid_flush), .o_idex_flush(sat_idex_flush),
    .o_busy(sat_busy), .o_done(sat_done), .o_cycle_cnt(sat_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: which activity the sequencer is in, drain budget left,
  // whether a halt is pending, the enabled-cycle tally and the done pulse.
  bit              m_run, m_step, m_drain, m_fin, m_pend, m_pulse;
  int              m_left;
  longint unsigned m_cnt;

  // Outputs sampled in the most recent tick.
  logic        s_ready, s_pipe_en, s_pc_we, s_ifid_we, s_ifid_flush, s_idex_flush;
  logic        s_busy, s_done;
  logic [31:0] s_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_step = 0; m_drain = 0; m_fin = 0; m_pend = 0; m_pulse = 0;
    m_left = 0; m_cnt = 0;
  endtask

  task automatic model_clock(input bit v, input bit [1:0] c, input bit pc, input bit h);
    bit acc, abort, hq, en, was_fin;
    acc     = v && !m_step;
    abort   = acc && (c == 2'b11);
    hq      = h && !pc;
    en      = m_run || m_step || m_drain;
    was_fin = m_fin;
    if (en && m_cnt != 64'hFFFF_FFFF) m_cnt++;
    if (m_run) begin
      if (abort) m_run = 0;
      else if (hq) begin m_run = 0; m_drain = 1; m_left = D; end
    end else if (m_step) begin
      m_step = 0;
      if (m_pend) begin
        if (m_left <= 1) begin m_fin = 1; m_pend = 0; m_left = 0; end
        else m_left--;
      end else if (hq) begin
        m_pend = 1; m_left = D;
      end
    end else if (m_drain) begin
      if (abort) begin m_drain = 0; m_pend = 1; end
      else if (pc) begin m_drain = 0; m_run = 1; m_left = 0; m_pend = 0; end
      else if (m_left <= 1) begin m_drain = 0; m_fin = 1; m_left = 0; m_pend = 0; end
      else m_left--;
    end else if (m_fin) begin
      if (abort) begin m_fin = 0; m_pend = 0; end
    end else if (acc) begin
      case (c)
        2'b01: if (m_pend) m_drain = 1; else m_run = 1;
        2'b10: m_step = 1;
        2'b11: m_pend = 0;
        default: ;
      endcase
    end
    m_pulse = m_fin && !was_fin;
  endtask

  // One clock cycle: drive inputs, compare every output mid-cycle against the
  // model, then advance the model across the rising edge.
  task automatic tick(input bit v, input bit [1:0] c, input bit pc, input bit lu, input bit h);
    bit en;
    i_cmd_valid = v; i_cmd = c; i_pc_src = pc; i_load_use = lu; i_halt_id = h;
    @(negedge i_clk);
    s_ready = o_cmd_ready; s_pipe_en = o_pipe_en; s_pc_we = o_pc_we;
    s_ifid_we = o_ifid_we; s_ifid_flush = o_ifid_flush; s_idex_flush = o_idex_flush;
    s_busy = o_busy; s_done = o_done; s_cnt = o_cycle_cnt;
    en = m_run || m_step || m_drain;
    check("cmd_ready",  s_ready,      !m_step);
    check("pipe_en",    s_pipe_en,    en);
    check("pc_we",      s_pc_we,      en && (m_drain ? pc : (pc || !lu)));
    check("ifid_we",    s_ifid_we,    en && !lu);
    check("ifid_flush", s_ifid_flush, en && (pc || m_drain));
    check("idex_flush", s_idex_flush, en && (pc || lu));
    check("busy",       s_busy,       m_run || m_drain);
    check("done",       s_done,       m_pulse);
    check("cycle_cnt",  s_cnt,        m_cnt);
    @(posedge i_clk);
    model_clock(v, c, pc, h);
    #1;
  endtask

  task automatic do_reset();
    i_cmd_valid = 0; i_cmd = 0; i_pc_src = 0; i_load_use = 0; i_halt_id = 0;
    i_reset = 1;
    @(posedge i_clk);
    #1;
    i_reset = 0;
    model_reset();
  endtask

  initial begin
    logic [31:0] frozen;
    model_reset();
    #1;
    do_reset();

    // Reset state, then continuous run with HALT at cycle 10.
    tick(1, 2'b01, 0, 0, 0);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick(0, 2'b00, 0, 0, cyc == 10);
      if (cyc >= 11 && cyc <= 14) begin
        check("drain_pc_we", s_pc_we, 0);
        check("drain_flush", s_ifid_flush, 1);
      end
      if (cyc == 15) begin
        check("halt_done", s_done, 1);
        check("halt_cnt", s_cnt, 14);
        check("halt_busy", s_busy, 0);
      end
    end

    // Abort in DONE, then a fresh run executes.
    tick(1, 2'b11, 0, 0, 0);
    tick(1, 2'b01, 0, 0, 0);
    tick(0, 2'b00, 0, 0, 0);
    check("rerun_en", s_pipe_en, 1);

    // Load-use, then load-use together with a taken branch.
    tick(0, 2'b00, 0, 1, 0);
    check("lu_pc_we", s_pc_we, 0);
    check("lu_ifid_we", s_ifid_we, 0);
    check("lu_idex_flush", s_idex_flush, 1);
    tick(0, 2'b00, 1, 1, 0);
    check("lu_br_pc_we", s_pc_we, 1);
    check("lu_br_ifid_flush", s_ifid_flush, 1);
    check("lu_br_idex_flush", s_idex_flush, 1);

    // Abort in RUN freezes the counter.
    tick(1, 2'b11, 0, 0, 0);
    tick(0, 2'b00, 0, 0, 0);
    check("abort_en", s_pipe_en, 0);
    frozen = s_cnt;
    tick(0, 2'b00, 0, 0, 0);
    check("abort_cnt_frozen", s_cnt, frozen);

    // Step mode: three steps, HALT on the third, then four more steps.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, 2'b10, 0, 0, 0);
      tick(0, 2'b00, 0, 0, i == 2);
      check("step_en", s_pipe_en, 1);
    end
    tick(0, 2'b00, 0, 0, 0);
    check("step_cnt", s_cnt, 3);
    for (int i = 0; i < 4; i++) begin
      tick(1, 2'b10, 0, 0, 0);
      check("step_no_done", s_done, 0);
      tick(0, 2'b00, 0, 0, 0);
    end
    tick(0, 2'b00, 0, 0, 0);
    check("step_done", s_done, 1);
    check("step_cnt7", s_cnt, 7);

    // Wrong-path HALT: branch taken in the second DRAIN cycle.
    do_reset();
    tick(1, 2'b01, 0, 0, 0);
    tick(0, 2'b00, 0, 0, 0);
    tick(0, 2'b00, 0, 0, 1);
    tick(0, 2'b00, 0, 0, 0);
    tick(0, 2'b00, 1, 0, 0);
    check("wp_pc_we", s_pc_we, 1);
    for (int i = 0; i < 6; i++) begin
      tick(0, 2'b00, 0, 0, 0);
      check("wp_no_done", s_done, 0);
      check("wp_busy", s_busy, 1);
    end

    // Async reset pulsed between edges during DRAIN.
    do_reset();
    tick(1, 2'b01, 0, 0, 0);
    tick(0, 2'b00, 0, 0, 1);
    tick(0, 2'b00, 0, 0, 0);
    #2 i_reset = 1;
    #1;
    check("ar_ready", o_cmd_ready, 1);
    check("ar_pipe_en", o_pipe_en, 0);
    check("ar_pc_we", o_pc_we, 0);
    check("ar_ifid_we", o_ifid_we, 0);
    check("ar_ifid_flush", o_ifid_flush, 0);
    check("ar_busy", o_busy, 0);
    check("ar_done", o_done, 0);
    check("ar_cnt", o_cycle_cnt, 0);
    #1 i_reset = 0;
    model_reset();
    @(posedge i_clk);
    #1;

    // Counter saturation on the narrow instance.
    do_reset();
    tick(1, 2'b01, 0, 0, 0);
    for (int i = 0; i < 14; i++) tick(0, 2'b00, 0, 0, 0);
    check("sat_cnt14", sat_cnt, 14);
    for (int i = 0; i < 6; i++) tick(0, 2'b00, 0, 0, 0);
    check("sat_cnt15", sat_cnt, 15);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
